regfile_write_ctrl: RTL

REGFILE_WRITE_CTRL -- requirements
Module: regfile_write_ctrl

---
 rtl/regfile_write_ctrl_pkg.sv | 16 +
 rtl/regfile_write_ctrl_rr_arb2.sv | 41 ++++
 rtl/regfile_write_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/regfile_write_ctrl_pkg.sv
// Shared widths, FSM state encoding and request type for the register-file
// write controller.
package regfile_write_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant from the valids, with a flop
// remembering whether B won the last granted cycle.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_b_q;
    logic last_b_d;
    logic [1:0] gnt;

    always_comb begin
        gnt      = 2'b00;
        last_b_d = last_b_q;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt = last_b_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req_i;
            end
            if (|gnt) begin
                last_b_d = gnt[1];
            end
        end
    end

    assign gnt_o = gnt;

    // Resetting to "B granted last" makes A win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Register-file write port controller: clears the file after reset, then
// arbitrates two write requesters onto one registered write port.
module regfile_write_ctrl
    import regfile_write_ctrl_pkg::*;
#(
    parameter int CLEAR_ON_RESET = 1,
    parameter int NREGS          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              init_done
);

    localparam logic [0:0]        ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic              init_done_q, init_done_d;

    logic       run_en;
    logic [1:0] gnt;
    wr_req_t    sel;

    // Gating with reset keeps ready low while reset is held, even when the
    // block resets straight into RUN.
    assign run_en = (state_q == ST_RUN) && !reset;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en_i  (run_en),
        .req_i ({b_valid, a_valid}),
        .gnt_o (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];
    assign sel     = gnt[1] ? wr_req_t'{addr: b_addr, data: b_data}
                            : wr_req_t'{addr: a_addr, data: a_data};

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        regwrite_d  = 1'b0;
        a3_d        = a3_q;
        wd3_d       = wd3_q;
        init_done_d = init_done_q | (state_q == ST_RUN);
        case (state_q)
            ST_CLEAR: begin
                regwrite_d = 1'b1;
                a3_d       = cnt_q;
                wd3_d      = '0;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Writes to x0 complete the handshake but never reach the file.
                if (|gnt) begin
                    regwrite_d = (sel.addr != '0);
                    a3_d       = sel.addr;
                    wd3_d      = sel.data;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            regwrite_q  <= 1'b0;
            a3_q        <= '0;
            wd3_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            regwrite_q  <= regwrite_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
            init_done_q <= init_done_d;
        end
    end

    assign RegWrite  = regwrite_q;
    assign A3        = a3_q;
    assign WD3       = wd3_q;
    assign init_done = init_done_q;

endmodule
